// File: rtl/riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : riscv_muldiv_unit
// Purpose  : Iterative RISC-V M-extension multiply/divide unit. It runs one
//            radix-2 step per cycle: shift-add for the MUL class and
//            restoring shift-subtract for the DIV class. Latency is WIDTH+2
//            edges from the accept edge to the DONE edge.
// Ports    : clk     - system clock (rising edge)
//            reset   - asynchronous, active-high reset
//            start   - request strobe, sampled only while busy=0
//            funct3  - 000 MUL 001 MULH 010 MULHSU 011 MULHU
//                      100 DIV 101 DIVU 110 REM 111 REMU
//            a, b    - operands rs1 / rs2
//            busy    - operation in progress
//            done    - one-cycle strobe, result/zero are new
//            result  - registered result, held until the next done
//            zero    - registered (result == 0)
// Config   : MULDIV_EARLY_OUT_EN - when defined, division by zero and signed
//            overflow skip CALC and complete with latency 2.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t             state, state_next;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand (MUL class) or divisor (DIV class)
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_q;    // final negation of the selected result
  logic [CW-1:0]      count_q;

  // Operand classification on the latched request
  logic             is_div, a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_by_zero, overflow, special;

  always_comb begin
    is_div      = op_q[2];
    a_signed    = is_div ? ~op_q[0] : ((op_q == 3'b001) || (op_q == 3'b010));
    b_signed    = is_div ? ~op_q[0] : (op_q == 3'b001);
    a_neg       = a_signed & a_q[WIDTH-1];
    b_neg       = b_signed & b_q[WIDTH-1];
    a_mag       = a_neg ? -a_q : a_q;
    b_mag       = b_neg ? -b_q : b_q;
    div_by_zero = is_div && (b_q == '0);
    overflow    = is_div && !op_q[0] && (a_q == {1'b1, {(WIDTH-1){1'b0}}})
                  && (b_q == '1);
    special     = div_by_zero | overflow;
  end

  // One iteration step of each algorithm
  logic [WIDTH:0]     mul_sum, div_rem_sh, div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step;

  always_comb begin
    // Shift-add: multiplier sits in the low half and is consumed LSB first;
    // the carry out of the partial-product add shifts into the high half.
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_step   = {mul_sum, acc_q[WIDTH-1:1]};
    // Restoring division: the partial remainder needs one extra bit after
    // the shift, and the quotient bit enters the low half from the right.
    div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff   = div_rem_sh - {1'b0, opnd_q};
    div_step   = div_diff[WIDTH]
                 ? {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                 : {div_diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
  end

  // Final sign correction and result selection
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   div_val, div_res, fix_result;

  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    div_val = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
    div_res = neg_q ? -div_val : div_val;
    if (div_by_zero)
      fix_result = op_q[1] ? a_q : '1;
    else if (overflow)
      fix_result = op_q[1] ? '0 : a_q;
    else if (is_div)
      fix_result = div_res;
    else if (op_q[1:0] == 2'b00)
      fix_result = prod[WIDTH-1:0];
    else
      fix_result = prod[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = PREP;
      PREP: begin
`ifdef MULDIV_EARLY_OUT_EN
        state_next = special ? FIX : CALC;
`else
        state_next = CALC;
`endif
      end
      CALC: if (count_q == '0) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
      result  <= '0;
      zero    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= funct3;
          end
        end
        PREP: begin
          opnd_q  <= is_div ? b_mag : a_mag;
          acc_q   <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
          // Remainder sign follows the dividend; everything else is a ^ b.
          neg_q   <= (is_div && op_q[1]) ? a_neg : (a_neg ^ b_neg);
          count_q <= CW'(WIDTH-1);
        end
        CALC: begin
          acc_q <= is_div ? div_step : mul_step;
          if (count_q != '0) count_q <= count_q - 1'b1;
        end
        FIX: begin
          result <= fix_result;
          zero   <= (fix_result == '0);
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Only the early-out build consumes this flag outside FIX.
  logic unused_special;
  assign unused_special = special;

endmodule
`default_nettype wire
